// File: rtl/loader_pkg.sv
// Shared types and helpers for the boot-time instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int MAX_WORDS_DEF = 1024;

    function automatic logic len_ok(input logic [15:0] n, input int unsigned max_words);
        return {16'h0000, n} <= max_words;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/loader_word_asm.sv
// Packs four consecutive bytes into a little-endian 32-bit word.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt;
    logic [31:0] shreg;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= 2'd0;
        end else if (load) begin
            cnt <= cnt + 2'd1;
        end
    end

    // Shift toward the LSB so the first byte ends up in bits [7:0].
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= {byte_in, shreg[31:8]};
        end
    end

    assign word      = shreg;
    assign word_full = load && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader; holds the core in reset until a checksummed image is resident.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = MAX_WORDS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      stream,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_t          state;
    state_t          state_nxt;
    logic            xfer;
    logic [7:0]      len_lo;
    logic [15:0]     n_words;
    logic [15:0]     n_form;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] word_idx_inc;
    logic [7:0]      sum;
    logic [7:0]      sum_nxt;
    logic            last_word;
    logic            asm_load;
    logic            asm_clr;
    logic            word_full;
    logic [31:0]     word;
    logic            ready;

    assign xfer         = stream.in_valid && ready;
    assign n_form       = {stream.in_data, len_lo};
    assign sum_nxt      = sum + stream.in_data;
    assign word_idx_inc = word_idx + 1'b1;
    assign last_word    = (16'(word_idx_inc) == n_words);
    assign asm_load     = (state == DATA) && xfer;
    assign asm_clr      = (state == HDR1);

    loader_word_asm u_word_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .load      (asm_load),
        .byte_in   (stream.in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= HDR0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR0: if (xfer) state_nxt = HDR1;
            HDR1: begin
                if (xfer) begin
                    if (!len_ok(n_form, MAX_WORDS)) begin
                        state_nxt = ERR;
                    end else if (n_form == 16'd0) begin
                        state_nxt = CSUM;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA:  if (word_full) state_nxt = WRITE;
            WRITE: state_nxt = last_word ? CSUM : DATA;
            CSUM: begin
                if (xfer) begin
                    state_nxt = (sum_nxt == 8'd0) ? DONE : ERR;
                end
            end
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = ERR;
        endcase
    end

    // Control bookkeeping: word index and running payload sum.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_idx <= '0;
            sum      <= 8'd0;
        end else begin
            if (state == HDR1 && xfer) begin
                word_idx <= '0;
                sum      <= 8'd0;
            end
            if (state == DATA && xfer) begin
                sum <= sum_nxt;
            end
            if (state == WRITE) begin
                word_idx <= word_idx_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == HDR0 && xfer) begin
            len_lo <= stream.in_data;
        end
        if (state == HDR1 && xfer) begin
            n_words <= n_form;
        end
    end

    // Every externally visible control output is forced low while reset is held.
    always_comb begin
        ready        = 1'b0;
        imem_we      = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        words_loaded = '0;
        if (rst) begin
            ready        = (state == HDR0) || (state == HDR1) ||
                           (state == DATA) || (state == CSUM);
            imem_we      = (state == WRITE);
            done         = (state == DONE);
            error        = (state == ERR);
            words_loaded = word_idx;
        end
    end

    assign stream.in_ready = ready;
    assign core_rst_n      = done;
    assign imem_addr       = word_idx[ADDR_W-1:0];
    assign imem_wdata      = word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a frame-level model of the byte protocol.
module tb_imem_loader;
    import loader_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .stream       (bus),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_rst_n   (core_rst_n),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    int total = 0;
    int bad   = 0;

    // Frame under test and model progress through it
    logic [7:0]  fb[$];
    bit          sum_ok;
    int          acc;
    bit          pend;
    int          wl;
    bit          chk_en;
    int          we_cnt;
    logic [31:0] seen [0:MAX_WORDS-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int fr_n();
        if (fb.size() < 2) return 0;
        return int'({fb[1], fb[0]});
    endfunction

    function automatic logic [31:0] fr_word(input int j);
        return {fb[2+4*j+3], fb[2+4*j+2], fb[2+4*j+1], fb[2+4*j]};
    endfunction

    function automatic bit calc_sum_ok();
        int n;
        int s;
        n = fr_n();
        s = 0;
        if (n > MAX_WORDS || fb.size() < 4*n+3) return 1'b0;
        for (int i = 2; i <= 4*n+2; i++) s += int'(fb[i]);
        return (s % 256) == 0;
    endfunction

    task automatic mk_frame(input int n, input bit good);
        logic [7:0] s;
        logic [7:0] b;
        fb.delete();
        fb.push_back(8'(n));
        fb.push_back(8'(n >> 8));
        s = 8'd0;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(255));
            fb.push_back(b);
            s = s + b;
        end
        fb.push_back(good ? 8'(-s) : 8'(-s) + 8'(1 + $urandom_range(254)));
        sum_ok = calc_sum_ok();
    endtask

    task automatic set_test1(input logic [7:0] cs);
        fb = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'hEF, 8'hBE, 8'hAD, 8'hDE, cs};
        sum_ok = calc_sum_ok();
    endtask

    task automatic clear_seen();
        we_cnt = 0;
        for (int i = 0; i < MAX_WORDS; i++) seen[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input int stop_at, input int vprob, input int budget, input int exp_cnt);
        int idx;
        int cyc;
        bit t;
        idx = 0;
        cyc = 0;
        while (idx < fb.size() && idx < stop_at && cyc < budget) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(99) < vprob);
            bus.in_data  = fb[idx];
            #1;
            t = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (t) idx++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("accepted_bytes", 32'(idx), 32'(exp_cnt));
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #3;
    endtask

    // Model advance: counts accepted bytes and schedules the write that follows each 4th payload byte
    int mn;
    int mp;
    bit mt;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            mt = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (!rst) begin
                acc  = 0;
                pend = 1'b0;
                wl   = 0;
            end else begin
                if (pend) begin
                    wl++;
                    pend = 1'b0;
                end
                if (mt) begin
                    acc++;
                    mn = fr_n();
                    mp = acc - 2;
                    if (acc > 2 && mn <= MAX_WORDS && mp % 4 == 0 && mp <= 4*mn) pend = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    int  cn;
    bit  c_over;
    bit  c_fin;
    bit  c_done;
    bit  c_err;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                if (!rst) begin
                    chk("rst_we", 32'(imem_we), 32'd0);
                    chk("rst_ready", 32'(bus.in_ready), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_error", 32'(error), 32'd0);
                    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
                    chk("rst_words_loaded", 32'(words_loaded), 32'd0);
                end else begin
                    cn     = fr_n();
                    c_over = (acc >= 2) && (cn > MAX_WORDS);
                    c_fin  = (acc >= 2) && !c_over && (acc == 4*cn+3);
                    c_done = c_fin && sum_ok;
                    c_err  = c_over || (c_fin && !sum_ok);
                    chk("imem_we", 32'(imem_we), 32'(pend));
                    if (imem_we === 1'b1) begin
                        we_cnt++;
                        seen[imem_addr] = imem_wdata;
                        if (pend) begin
                            chk("imem_addr", 32'(imem_addr), 32'(wl));
                            chk("imem_wdata", imem_wdata, fr_word(wl));
                        end
                    end
                    chk("in_ready", 32'(bus.in_ready), 32'(!pend && !c_done && !c_err));
                    chk("done", 32'(done), 32'(c_done));
                    chk("error", 32'(error), 32'(c_err));
                    chk("core_rst_n", 32'(core_rst_n), 32'(c_done));
                    chk("words_loaded", 32'(words_loaded), 32'(wl));
                    chk("done_and_error", 32'(done && error), 32'd0);
                end
            end
        end
    end

    int n;
    int vp;
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        acc    = 0;
        pend   = 1'b0;
        wl     = 0;
        sum_ok = 1'b0;
        chk_en = 1'b1;
        clear_seen();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Good two-word load
        set_test1(8'hB5);
        send(100, 100, 200, 11);
        settle();
        chk("t1_mem0", seen[0], 32'h00000013);
        chk("t1_mem1", seen[1], 32'hDEADBEEF);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("t1_words_loaded", 32'(words_loaded), 32'd2);
        chk("t1_we_cnt", 32'(we_cnt), 32'd2);

        // Bad checksum
        do_reset();
        clear_seen();
        set_test1(8'hB4);
        send(100, 100, 200, 11);
        settle();
        chk("t2_we_cnt", 32'(we_cnt), 32'd2);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("t2_ready", 32'(bus.in_ready), 32'd0);

        // Empty program
        do_reset();
        clear_seen();
        fb = '{8'h00, 8'h00, 8'h00};
        sum_ok = calc_sum_ok();
        send(100, 100, 50, 3);
        settle();
        chk("t3_we_cnt", 32'(we_cnt), 32'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_words_loaded", 32'(words_loaded), 32'd0);

        // Oversize length stops after the header
        do_reset();
        clear_seen();
        fb = '{8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        sum_ok = 1'b0;
        send(100, 100, 30, 2);
        settle();
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_we_cnt", 32'(we_cnt), 32'd0);

        // Stalled delivery of the good frame
        do_reset();
        clear_seen();
        set_test1(8'hB5);
        send(100, 50, 400, 11);
        settle();
        chk("t5_mem0", seen[0], 32'h00000013);
        chk("t5_mem1", seen[1], 32'hDEADBEEF);
        chk("t5_done", 32'(done), 32'd1);

        // Reset after five payload bytes, then replay
        do_reset();
        clear_seen();
        set_test1(8'hB5);
        send(7, 100, 50, 7);
        do_reset();
        chk("t6_after_rst_wl", 32'(words_loaded), 32'd0);
        chk("t6_after_rst_done", 32'(done), 32'd0);
        send(100, 100, 200, 11);
        settle();
        chk("t6_mem0", seen[0], 32'h00000013);
        chk("t6_mem1", seen[1], 32'hDEADBEEF);
        chk("t6_done", 32'(done), 32'd1);

        // Random frames, random stalls, random checksum validity
        for (int k = 0; k < 8; k++) begin
            do_reset();
            clear_seen();
            n  = $urandom_range(1, 8);
            vp = $urandom_range(30, 100);
            mk_frame(n, $urandom_range(1) == 1);
            send(100000, vp, (4*n+3)*400/vp + 2*n + 50, 4*n+3);
            settle();
            chk("rand_we_cnt", 32'(we_cnt), 32'(n));
        end

        // Largest legal program: last write lands at MAX_WORDS-1
        do_reset();
        clear_seen();
        mk_frame(MAX_WORDS, 1'b1);
        send(100000, 100, 6000, 4*MAX_WORDS+3);
        settle();
        chk("max_done", 32'(done), 32'd1);
        chk("max_words_loaded", 32'(words_loaded), 32'(MAX_WORDS));
        chk("max_we_cnt", 32'(we_cnt), 32'(MAX_WORDS));
        chk("max_last_word", seen[MAX_WORDS-1], fr_word(MAX_WORDS-1));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
